// File: rtl/hazard_scoreboard_ctrl.sv
// hazard_scoreboard_ctrl: per-register write scoreboard with stall/flush/bubble/freeze sequencing for a 5-stage RV32I core without forwarding.
// Optional macro HAZARD_PERF_EN adds the stall_cycles RAW-stall counter output.
module hazard_scoreboard_ctrl #(
   parameter int MAX_INFLIGHT = 3,
   parameter bit WB_BYPASS    = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] id_instr,
   input  logic        id_valid,
   input  logic        ex_redirect,
   input  logic        mem_busy,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   output logic        stall_pc,
   output logic        stall_ifid,
   output logic        flush_ifid,
   output logic        bubble_idex,
   output logic        freeze,
   output logic        illegal_instr
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] stall_cycles
`endif
);
   localparam int CW = $clog2(MAX_INFLIGHT + 1);

   logic [6:0]    opc;
   logic [4:0]    rd, rs1, rs2;
   logic          is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_imm, is_op;
   logic          use1, use2, wr, legal;
   logic          raw1, raw2, raw, issue, dec_en;
   logic [31:0]   inc_v, dec_v;
   logic [CW-1:0] cnt     [32];
   logic [CW-1:0] cnt_nxt [32];
   logic          unused_bits;

   assign opc = id_instr[6:0];
   assign rd  = id_instr[11:7];
   assign rs1 = id_instr[19:15];
   assign rs2 = id_instr[24:20];
   assign unused_bits = ^{id_instr[31:25], id_instr[14:12]};

   assign is_lui   = opc == 7'b0110111;
   assign is_auipc = opc == 7'b0010111;
   assign is_jal   = opc == 7'b1101111;
   assign is_jalr  = opc == 7'b1100111;
   assign is_br    = opc == 7'b1100011;
   assign is_ld    = opc == 7'b0000011;
   assign is_st    = opc == 7'b0100011;
   assign is_imm   = opc == 7'b0010011;
   assign is_op    = opc == 7'b0110011;

   assign use1  = (is_jalr | is_imm | is_ld | is_br | is_st | is_op) & (rs1 != 5'd0);
   assign use2  = (is_br | is_st | is_op) & (rs2 != 5'd0);
   assign wr    = (is_lui | is_auipc | is_jal | is_jalr | is_imm | is_op | is_ld) & (rd != 5'd0);
   assign legal = is_lui | is_auipc | is_jal | is_jalr | is_br | is_ld | is_st | is_imm | is_op;

   // A source whose single pending write retires this cycle is readable through the write-through file.
   assign raw1 = use1 & (cnt[rs1] != '0) &
                 ~(WB_BYPASS & (cnt[rs1] == CW'(1)) & wb_valid & (wb_rd == rs1));
   assign raw2 = use2 & (cnt[rs2] != '0) &
                 ~(WB_BYPASS & (cnt[rs2] == CW'(1)) & wb_valid & (wb_rd == rs2));
   assign raw  = id_valid & (raw1 | raw2);

   assign issue  = id_valid & ~raw & ~ex_redirect & ~mem_busy;
   assign dec_en = wb_valid & ~mem_busy & (wb_rd != 5'd0);
   assign inc_v  = (issue & wr) ? (32'd1 << rd) : 32'd0;
   assign dec_v  = dec_en ? (32'd1 << wb_rd) : 32'd0;

   assign freeze      = mem_busy;
   assign stall_pc    = mem_busy | (~ex_redirect & raw);
   assign stall_ifid  = mem_busy | (~ex_redirect & raw);
   assign flush_ifid  = ~mem_busy & ex_redirect;
   assign bubble_idex = ~mem_busy & (ex_redirect | raw);

   always_comb begin
      cnt_nxt = cnt;
      for (int r = 0; r < 32; r++)
         cnt_nxt[r] = (inc_v[r] & ~dec_v[r] & (cnt[r] != CW'(MAX_INFLIGHT))) ? cnt[r] + CW'(1) :
                      (dec_v[r] & ~inc_v[r] & (cnt[r] != '0))                ? cnt[r] - CW'(1) : cnt[r];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < 32; r++) cnt[r] <= '0;
         illegal_instr <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         if (issue) illegal_instr <= ~legal;
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_cycles <= '0;
      else if (raw & ~mem_busy & ~ex_redirect) stall_cycles <= stall_cycles + 32'd1;
   end
`endif
endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// tb_hazard_scoreboard_ctrl: directed vectors for hazard_scoreboard_ctrl (default parameters, WB_BYPASS=1).
module tb_hazard_scoreboard_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] id_instr = 32'd0;
   logic        id_valid = 1'b0;
   logic        ex_redirect = 1'b0;
   logic        mem_busy = 1'b0;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_rd = 5'd0;
   logic        stall_pc, stall_ifid, flush_ifid, bubble_idex, freeze, illegal_instr;
   int          checks = 0;
   int          failures = 0;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles;
`endif

   localparam logic [4:0] NONE = 5'b00000;
   localparam logic [4:0] RAW  = 5'b11010;
   localparam logic [4:0] RED  = 5'b00110;
   localparam logic [4:0] FRZ  = 5'b11001;

   hazard_scoreboard_ctrl dut (
      .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
      .ex_redirect(ex_redirect), .mem_busy(mem_busy), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
      .bubble_idex(bubble_idex), .freeze(freeze), .illegal_instr(illegal_instr)
`ifdef HAZARD_PERF_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] addi(input logic [4:0] d, input logic [4:0] s1);
      return {12'd0, s1, 3'b000, d, 7'b0010011};
   endfunction
   function automatic logic [31:0] add(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
      return {7'd0, s2, s1, 3'b000, d, 7'b0110011};
   endfunction
   function automatic logic [31:0] sw(input logic [4:0] s1, input logic [4:0] s2);
      return {7'd0, s2, s1, 3'b010, 5'd0, 7'b0100011};
   endfunction
   function automatic logic [31:0] bad(input logic [4:0] d);
      return {20'd0, d, 7'b1111111};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, check the combinational controls mid-cycle, then advance past the edge.
   task automatic cyc(input string tag, input logic [31:0] ins, input logic v, input logic redir,
                      input logic busy, input logic wbv, input logic [4:0] wbr, input logic [4:0] exp);
      id_instr = ins; id_valid = v; ex_redirect = redir; mem_busy = busy; wb_valid = wbv; wb_rd = wbr;
      #1;
      check(tag, {27'd0, stall_pc, stall_ifid, flush_ifid, bubble_idex, freeze}, {27'd0, exp});
      @(posedge clk); #1;
   endtask

   initial begin
      #2;
      check("reset_ctl", {27'd0, stall_pc, stall_ifid, flush_ifid, bubble_idex, freeze}, 32'd0);
      check("reset_illegal", {31'd0, illegal_instr}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      // back-to-back dependence on x5, released by bypass in the retire cycle
      cyc("addi_x5",       addi(5, 0),   1, 0, 0, 0, 0, NONE);
      cyc("dep_x5_a",      add(6, 5, 5), 1, 0, 0, 0, 0, RAW);
      cyc("dep_x5_b",      add(6, 5, 5), 1, 0, 0, 0, 0, RAW);
      cyc("dep_x5_wb",     add(6, 5, 5), 1, 0, 0, 1, 5, NONE);
      // double writer on x7
      cyc("addi_x7_1",     addi(7, 0),   1, 0, 0, 0, 0, NONE);
      cyc("addi_x7_2",     addi(7, 0),   1, 0, 0, 0, 0, NONE);
      cyc("sw_x7_stall",   sw(0, 7),     1, 0, 0, 0, 0, RAW);
      cyc("sw_x7_wb1",     sw(0, 7),     1, 0, 0, 1, 7, RAW);
      cyc("sw_x7_after1",  sw(0, 7),     1, 0, 0, 0, 0, RAW);
      cyc("sw_x7_wb2",     sw(0, 7),     1, 0, 0, 1, 7, NONE);
      cyc("x7_clear",      add(8, 7, 7), 1, 0, 0, 1, 6, NONE);
      // simultaneous issue and retire of x9
      cyc("addi_x9",       addi(9, 0),   1, 0, 0, 0, 0, NONE);
      cyc("x9_iss_ret",    addi(9, 0),   1, 0, 0, 1, 9, NONE);
      cyc("x9_pending",    add(10, 9, 0), 1, 0, 0, 0, 0, RAW);
      cyc("x9_is_one",     add(10, 9, 0), 1, 0, 0, 1, 9, NONE);
      // redirect during a RAW stall discards the ID instruction
      cyc("raw_x10",       add(11, 10, 10), 1, 0, 0, 0, 0, RAW);
      cyc("redir_in_raw",  add(11, 10, 10), 1, 1, 0, 0, 0, RED);
      cyc("x11_uncounted", add(12, 11, 0),  1, 0, 0, 0, 0, NONE);
      // freeze for 3 cycles with wb and redirect pending
      for (int i = 0; i < 3; i++) cyc($sformatf("freeze_%0d", i), add(13, 12, 0), 1, 1, 1, 1, 12, FRZ);
      cyc("redir_after",   add(13, 12, 0), 1, 1, 0, 0, 0, RED);
      cyc("x12_kept",      add(13, 12, 0), 1, 0, 0, 0, 0, RAW);
      cyc("x12_wb",        add(13, 12, 0), 1, 0, 0, 1, 12, NONE);
      // saturation at MAX_INFLIGHT and no underflow
      for (int i = 0; i < 4; i++) cyc($sformatf("addi_x20_%0d", i), addi(20, 0), 1, 0, 0, 0, 0, NONE);
      cyc("sat_x20",       add(1, 20, 0), 1, 0, 0, 0, 0, RAW);
      cyc("sat_x20_wb1",   add(1, 20, 0), 1, 0, 0, 1, 20, RAW);
      cyc("sat_x20_wb2",   add(1, 20, 0), 1, 0, 0, 1, 20, RAW);
      cyc("sat_x20_wb3",   add(1, 20, 0), 1, 0, 0, 1, 20, NONE);
      cyc("under_x21",     32'd0,         0, 0, 0, 1, 21, NONE);
      cyc("addi_x21",      addi(21, 0),   1, 0, 0, 0, 0, NONE);
      cyc("x21_stall",     add(2, 21, 0), 1, 0, 0, 0, 0, RAW);
      cyc("x21_is_one",    add(2, 21, 0), 1, 0, 0, 1, 21, NONE);
      // illegal opcode handling and mid-stall reset
      check("illegal_pre", {31'd0, illegal_instr}, 32'd0);
      cyc("illegal_iss",   bad(14),       1, 0, 0, 0, 0, NONE);
      check("illegal_set", {31'd0, illegal_instr}, 32'd1);
      cyc("x14_uncounted", addi(15, 14),  1, 0, 0, 0, 0, NONE);
      check("illegal_clr", {31'd0, illegal_instr}, 32'd0);
      cyc("illegal_iss2",  bad(14),       1, 0, 0, 0, 0, NONE);
      check("illegal_set2", {31'd0, illegal_instr}, 32'd1);
      cyc("raw_x13",       add(16, 13, 0), 1, 0, 0, 0, 0, RAW);
      id_instr = add(16, 15, 13); id_valid = 1'b1;
      rst = 1'b1;
      #1;
      check("rst_ctl", {27'd0, stall_pc, stall_ifid, flush_ifid, bubble_idex, freeze}, 32'd0);
      check("rst_illegal", {31'd0, illegal_instr}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      cyc("post_rst",      add(16, 15, 13), 1, 0, 0, 0, 0, NONE);
`ifdef HAZARD_PERF_EN
      check("perf_after_rst", stall_cycles, 32'd0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hazard_scoreboard_ctrl.md
Name: hazard_scoreboard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core (IF, ID, EX, MEM, WB).
- Decodes the ID-stage instruction word using the team's instruction format package: opcode classes, rs1/rs2/rd fields.
- Keeps a per-register in-flight write scoreboard and generates stall, flush and bubble controls for a pipeline without forwarding.
- Also handles taken-branch/jump redirects from EX and global freezes from the memory stage.

Parameters:
- MAX_INFLIGHT, 3, max in-flight writers to one register after ID (EX+MEM+WB); counter width = $clog2(MAX_INFLIGHT+1).
- WB_BYPASS, 1, 1 = register file is write-through, so a source whose last pending write retires this cycle counts as ready.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- id_instr  in  32  ID-stage instruction word (instruction_t layout).
- id_valid  in  1  ID stage holds a real instruction.
- ex_redirect  in  1  EX resolved taken branch/JAL/JALR; held stable by EX while frozen.
- mem_busy  in  1  data memory not ready; whole pipeline must freeze.
- wb_valid  in  1  WB stage retires an instruction that writes rd.
- wb_rd  in  5  WB destination register.
- stall_pc  out  1  hold PC.
- stall_ifid  out  1  hold IF/ID register.
- flush_ifid  out  1  load NOP into IF/ID.
- bubble_idex  out  1  load NOP into ID/EX.
- freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- illegal_instr  out  1  registered: last issued ID instruction had an unknown opcode.

Behaviour:
- Decode, by opcode:
  - reads rs1 only: JALR, IMM, L.
  - reads rs1 and rs2: BRANCH, S, OP.
  - reads nothing: LUI, AUIPC, JAL.
  - writes rd: LUI, AUIPC, JAL, JALR, IMM, OP, L.
  - x0 is never pending and never counted.
  - any other opcode is illegal: it reads nothing and writes nothing.
- Scoreboard: cnt[1..31], each reset to 0.
  - issue = id_valid & ~raw & ~ex_redirect & ~mem_busy.
  - On issue of a writing instruction: cnt[rd]++.
  - On wb_valid & ~mem_busy & wb_rd!=0: cnt[wb_rd]--.
  - Increment and decrement of the same register in one cycle: count unchanged.
  - Saturating: no increment past MAX_INFLIGHT, no decrement below 0.
- RAW hazard: raw = id_valid and some used source s has cnt[s]!=0.
  - Exception when WB_BYPASS=1: if cnt[s]==1 and wb_valid & wb_rd==s, the source is ready.
- Priority, combinational, evaluated every cycle:
  1. mem_busy: freeze=stall_pc=stall_ifid=1; no flush or bubble; scoreboard frozen.
  2. ex_redirect: flush_ifid=1 and bubble_idex=1; stall_pc=0 (PC loads the target). The ID instruction is discarded, never counted.
  3. raw: stall_pc=stall_ifid=1 and bubble_idex=1.
  4. otherwise: all controls 0.
- Redirect is resolved in EX, so every younger instruction is still in IF/ID and unissued. The scoreboard never needs rollback.
- illegal_instr: set on the issue cycle of an illegal opcode (visible the next cycle); cleared on the next issue of a legal instruction.
- Reset, mid-operation included:
  - all counters 0; illegal_instr=0; perf counter 0.
  - combinational outputs follow from cnt=0, so they are 0 unless inputs assert.
- Freeze with a pending redirect: the redirect takes effect in the first cycle after mem_busy falls.
- Latency:
  - stall, flush and bubble act in the same cycle as the condition.
  - a counter change is visible to RAW detection the next cycle.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds output stall_cycles [31:0], reset 0.
  - Increments once per cycle where raw & ~mem_busy & ~ex_redirect.
  - Wraps at 2^32-1 to 0.
  - Not incremented during freeze or redirect cycles.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Back-to-back dependence: issue ADDI x5 (cnt[5]=1), then ADD x6,x5,x5 in ID.
  - Required: stall_pc=stall_ifid=bubble_idex=1 until the cycle wb_valid, wb_rd=5.
  - WB_BYPASS=1: release in that same cycle. WB_BYPASS=0: release one cycle later.
- Double writer: ADDI x7; ADDI x7; then SW x7 in ID.
  - Required: cnt[7] goes 1 then 2; stall persists through the first WB and releases only after the second WB.
- Simultaneous issue and retire of x9 (cnt[9]=1, wb_rd=9, ID issues ADDI x9).
  - Required: cnt[9] stays 1.
- Redirect during RAW stall: ex_redirect=1 while ID is stalled.
  - Required: flush_ifid=bubble_idex=1, stall_pc=0; ID instruction not counted.
- mem_busy held 3 cycles with wb_valid=1 and ex_redirect=1.
  - Required: freeze=1 and counters unchanged for all 3 cycles; redirect flush on the cycle after mem_busy falls.
- Illegal opcode 7'b1111111 issued.
  - Required: illegal_instr=1 next cycle and no counter change. Then assert rst mid-stall: all counters 0 and illegal_instr=0 immediately.
